char_stream_arbiter: RTL and testbench

Shares one 8-bit character output channel among N character-stream sources that use a valid/ready handshake. A whole message, terminated by `last`, is granted to one source at a time, and sources take turns in round-robin order. A programmable length cap forces a message boundary so that no source can hold the channel indefinitely. The block sits between the character generators and the single downstream character sink. It carries no storage beyond a one-entry output register.

---
 rtl/char_stream_arbiter.sv | 124 ++++++++++++
 tb/tb_char_stream_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_stream_arbiter.sv
// Round-robin arbiter that hands one 8-bit character channel to N valid/ready sources, one message at a time, with a byte cap.
// First byte appears two cycles after a request is seen idle; in_ready follows out_ready combinationally through a one-entry output register.
module char_stream_arbiter #(
    parameter int N      = 4,
    parameter int MAXLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [8*N-1:0]       in_data,
    input  logic [N-1:0]         in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_last,
    output logic [$clog2(N)-1:0] out_src,
    output logic                 busy
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAXLEN + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] g;
    logic [PW-1:0] ptr;
    logic [PW-1:0] sel;
    logic [PW-1:0] cand;
    logic [CW-1:0] cnt;
    logic          any_req;
    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          space;
    logic          xfer;
    logic          end_msg;

    // Scan downward so the lowest offset from ptr is the last (winning) assignment.
    always_comb begin
        sel     = ptr;
        cand    = ptr;
        any_req = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % N);
            if (in_valid[cand]) begin
                sel     = cand;
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (g == PW'(k)) begin
                g_valid = in_valid[k];
                g_last  = in_last[k];
                g_data  = in_data[8*k +: 8];
            end
        end
    end

    assign space   = !out_valid || out_ready;
    assign xfer    = (state == GRANT) && g_valid && space;
    assign end_msg = g_last || (cnt == CW'(MAXLEN - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (xfer && end_msg) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        busy     = (state == GRANT);
        if (state == GRANT) begin
            for (int k = 0; k < N; k++) begin
                if (g == PW'(k)) in_ready[k] = space;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g         <= '0;
            ptr       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                g   <= sel;
                cnt <= '0;
            end
            if (xfer) begin
                cnt       <= cnt + 1'b1;
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_last  <= end_msg;
                out_src   <= g;
                if (end_msg) ptr <= (g == PW'(N - 1)) ? '0 : g + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_char_stream_arbiter.sv
// Bench for char_stream_arbiter: queued sources, message-level round-robin model, scoreboard monitor.
module tb_char_stream_arbiter;
    localparam int NS = 4;
    localparam int ML = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     in_valid;
    logic [NS-1:0]     in_ready;
    logic [8*NS-1:0]   in_data;
    logic [NS-1:0]     in_last;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic              out_last;
    logic [1:0]        out_src;
    logic              busy;

    int total = 0;
    int bad   = 0;
    int mptr  = 0;
    int ready_mode = 0;

    logic [8:0]  src_q [NS][$];
    logic [8:0]  mq    [NS][$];
    logic [10:0] exp_q [$];
    logic [NS-1:0] acc;
    logic [10:0] m_got;
    logic [10:0] m_exp;

    char_stream_arbiter #(.N(NS), .MAXLEN(ML)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, want);
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int k = 0; k < NS; k++) if (src_q[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic push_byte(int s, logic lst, logic [7:0] d);
        src_q[s].push_back({lst, d});
        mq[s].push_back({lst, d});
    endtask

    task automatic load_str(int s, string txt);
        for (int i = 0; i < txt.len(); i++)
            push_byte(s, 1'(i == txt.len() - 1), 8'(txt[i]));
    endtask

    task automatic load_rand(int s, int len);
        for (int i = 0; i < len; i++)
            push_byte(s, 1'(i == len - 1), 8'($urandom));
    endtask

    // Whole-message reference: pick next source with data from the pointer, emit up to ML bytes.
    task automatic model_run();
        int s;
        int n;
        logic lst;
        logic [8:0] b;
        bit more = 1'b1;
        while (more) begin
            s = -1;
            for (int i = 0; i < NS; i++)
                if (s < 0 && mq[(mptr + i) % NS].size() > 0) s = (mptr + i) % NS;
            if (s < 0) begin
                more = 1'b0;
            end else begin
                n   = 0;
                lst = 1'b0;
                while (!lst) begin
                    b   = mq[s].pop_front();
                    n++;
                    lst = b[8] || (n == ML);
                    exp_q.push_back({2'(s), lst, b[7:0]});
                end
                mptr = (s + 1) % NS;
            end
        end
    endtask

    task automatic wait_done(string name, int budget);
        int c = 0;
        while ((exp_q.size() > 0 || pending()) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(exp_q.size() == 0 && !pending()), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Source driver: pops accepted bytes and presents queue heads just after each edge.
    always @(negedge clk) acc = rst ? (in_valid & in_ready) : '0;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NS; k++) begin
            if (rst && acc[k] && src_q[k].size() > 0) src_q[k].delete(0);
            if (src_q[k].size() > 0) begin
                in_valid[k]        = 1'b1;
                in_last[k]         = src_q[k][0][8];
                in_data[8*k +: 8]  = src_q[k][0][7:0];
            end else begin
                in_valid[k]        = 1'b0;
                in_last[k]         = 1'b0;
                in_data[8*k +: 8]  = 8'h00;
            end
        end
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            m_got = {out_src, out_last, out_data};
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got=%h expected=none", m_got);
            end else begin
                m_exp = exp_q.pop_front();
                check("sb_byte", 32'(m_got), 32'(m_exp));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string pat;
        logic  gap_next;
        rst       = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Four simultaneous 3-byte messages from a fresh pointer.
        for (int k = 0; k < NS; k++) load_rand(k, 3);
        model_run();
        wait_done("simul_done", 500);

        // Alternating sources 1 and 3, loaded with 3 before 1.
        for (int m = 0; m < 3; m++) begin
            load_rand(3, 2);
            load_rand(1, 2);
        end
        model_run();
        wait_done("fair_done", 500);

        // Cycle-exact latency, throughput, cap and bubble on a single source.
        load_str(0, "JUSTMONIKA");
        model_run();
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("grant_busy", 32'(busy), 32'd1);
        check("grant_in_ready", 32'(in_ready), 32'b0001);
        pat = "JUST_MONI_KA";
        for (int i = 0; i < pat.len(); i++) begin
            @(negedge clk);
            if (pat[i] == 8'h5F) begin
                check("a_gap", 32'(out_valid), 32'd0);
            end else begin
                gap_next = (i == pat.len() - 1) ? 1'b1 : (pat[i + 1] == 8'h5F);
                check("a_byte", 32'({out_valid, out_last, out_data}),
                      32'({1'b1, gap_next, 8'(pat[i])}));
            end
        end
        wait_done("a_done", 200);

        load_str(2, "ABCDEF");
        model_run();
        wait_done("cap_done", 200);

        // Five-cycle stall starting right after the second byte lands.
        load_str(1, "0123456789");
        model_run();
        repeat (3) @(negedge clk);
        ready_mode = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 32'({out_valid, out_data}), 32'({1'b1, 8'h31}));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        ready_mode = 0;
        wait_done("bp_done", 300);

        // Abandon a message after its third byte; pointer must restart at 0.
        load_str(2, "abcdefghij");
        model_run();
        repeat (5) @(negedge clk);
        check("f_third", 32'({out_valid, out_data}), 32'({1'b1, 8'h63}));
        #2 rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_data",  32'(out_data),  32'd0);
        check("mid_rst_out_last",  32'(out_last),  32'd0);
        check("mid_rst_out_src",   32'(out_src),   32'd0);
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        for (int k = 0; k < NS; k++) begin
            src_q[k].delete();
            mq[k].delete();
        end
        exp_q.delete();
        mptr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        load_str(3, "pq");
        load_str(0, "xy");
        model_run();
        wait_done("post_rst_done", 200);

        ready_mode = 1;
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < NS; k++) begin
                if ($urandom_range(0, 1) == 1 || k == r % NS) begin
                    for (int m = 0; m < int'($urandom_range(1, 3)); m++)
                        load_rand(k, int'($urandom_range(1, 9)));
                end
            end
            model_run();
            wait_done("rand_done", 3000);
        end
        ready_mode = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
